axi_lite_sram: RTL and testbench

AXI_LITE_SRAM -- requirements
Module: axi_lite_sram

---
 rtl/axi_lite_sram.sv | 175 +++++++++++++++++
 tb/tb_axi_lite_sram.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_sram.sv
// axi_lite_sram: AXI4-Lite slave over a word-addressed SRAM with independent read and write FSMs.
// Define AXI_LITE_SRAM_DECERR_EN to answer DECERR (2'b11) for addresses beyond the array.
//
// state   | meaning
// R_IDLE  | accepting AR
// R_WAIT  | counting down read latency
// R_RESP  | holding read data until rready_i
// W_IDLE  | collecting AW and W in either order
// W_WAIT  | counting down write latency
// W_RESP  | holding write response until bready_i
module axi_lite_sram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int DEPTH      = 1024,
    parameter int RD_LATENCY = 1,
    parameter int WR_LATENCY = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [ADDR_WIDTH-1:0] araddr_i,
    input  logic                  arvalid_i,
    output logic                  arready_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic [1:0]            rresp_o,
    output logic                  rvalid_o,
    input  logic                  rready_i,
    input  logic [ADDR_WIDTH-1:0] awaddr_i,
    input  logic                  awvalid_i,
    output logic                  awready_o,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [STRB_WIDTH-1:0] wstrb_i,
    input  logic                  wvalid_i,
    output logic                  wready_o,
    output logic [1:0]            bresp_o,
    output logic                  bvalid_o,
    input  logic                  bready_i
);
    localparam int BYTE_BITS = $clog2(STRB_WIDTH);
    localparam int IDX_BITS  = $clog2(DEPTH);
    localparam int MAX_LAT   = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int CNT_W     = $clog2(MAX_LAT) + 1;
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LATENCY - 1);

    localparam logic [1:0] R_IDLE = 2'd0, R_WAIT = 2'd1, R_RESP = 2'd2;
    localparam logic [1:0] W_IDLE = 2'd0, W_WAIT = 2'd1, W_RESP = 2'd2;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [1:0]            r_state, w_state;
    logic [CNT_W-1:0]      r_cnt, w_cnt;
    logic [IDX_BITS-1:0]   r_idx, w_idx;
    logic                  r_err, w_err;
    logic                  aw_done, w_done;
    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_WIDTH-1:0] w_strb;

    logic [IDX_BITS-1:0]   ar_idx, aw_idx;
    logic                  ar_err, aw_err;
    logic                  aw_take, w_take, w_commit;
    logic                  unused_addr;

    assign ar_idx = araddr_i[BYTE_BITS+IDX_BITS-1:BYTE_BITS];
    assign aw_idx = awaddr_i[BYTE_BITS+IDX_BITS-1:BYTE_BITS];
    // Sub-word bits (and, without DECERR, upper bits) are deliberately ignored.
    assign unused_addr = ^{araddr_i, awaddr_i};

`ifdef AXI_LITE_SRAM_DECERR_EN
    assign ar_err = |(araddr_i >> (BYTE_BITS + IDX_BITS));
    assign aw_err = |(awaddr_i >> (BYTE_BITS + IDX_BITS));
`else
    assign ar_err = 1'b0;
    assign aw_err = 1'b0;
`endif

    assign arready_o = (r_state == R_IDLE);
    assign awready_o = (w_state == W_IDLE) && !aw_done;
    assign wready_o  = (w_state == W_IDLE) && !w_done;
    assign aw_take   = awvalid_i && awready_o;
    assign w_take    = wvalid_i && wready_o;
    assign w_commit  = (w_state == W_WAIT) && (w_cnt == '0) && !w_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= R_IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_err    <= 1'b0;
            rdata_o  <= '0;
            rresp_o  <= 2'b00;
            rvalid_o <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: if (arvalid_i) begin
                    r_idx   <= ar_idx;
                    r_err   <= ar_err;
                    r_cnt   <= RD_LOAD;
                    r_state <= R_WAIT;
                end
                R_WAIT: if (r_cnt == '0) begin
                    // Sampled with a non-blocking read, so a same-edge write is not visible.
                    rdata_o  <= r_err ? '0 : mem[r_idx];
                    rresp_o  <= r_err ? 2'b11 : 2'b00;
                    rvalid_o <= 1'b1;
                    r_state  <= R_RESP;
                end else begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                R_RESP: if (rready_i) begin
                    rvalid_o <= 1'b0;
                    r_state  <= R_IDLE;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_state  <= W_IDLE;
            w_cnt    <= '0;
            w_idx    <= '0;
            w_err    <= 1'b0;
            w_data   <= '0;
            w_strb   <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            bresp_o  <= 2'b00;
            bvalid_o <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_take) begin
                        w_idx   <= aw_idx;
                        w_err   <= aw_err;
                        aw_done <= 1'b1;
                    end
                    if (w_take) begin
                        w_data <= wdata_i;
                        w_strb <= wstrb_i;
                        w_done <= 1'b1;
                    end
                    if ((aw_done || aw_take) && (w_done || w_take)) begin
                        w_cnt   <= WR_LOAD;
                        w_state <= W_WAIT;
                    end
                end
                W_WAIT: if (w_cnt == '0) begin
                    bresp_o  <= w_err ? 2'b11 : 2'b00;
                    bvalid_o <= 1'b1;
                    w_state  <= W_RESP;
                end else begin
                    w_cnt <= w_cnt - CNT_W'(1);
                end
                W_RESP: if (bready_i) begin
                    bvalid_o <= 1'b0;
                    aw_done  <= 1'b0;
                    w_done   <= 1'b0;
                    w_state  <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Array has no reset; contents survive rst_ni.
    always_ff @(posedge clk_i) begin
        if (w_commit) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (w_strb[b]) mem[w_idx][8*b +: 8] <= w_data[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_axi_lite_sram.sv
// tb_axi_lite_sram: directed, table-driven bench for axi_lite_sram at default parameters.
module tb_axi_lite_sram;
    localparam int RD_LAT = 1;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic [31:0] araddr_i = '0;
    logic        arvalid_i = 1'b0;
    logic        arready_o;
    logic [31:0] rdata_o;
    logic [1:0]  rresp_o;
    logic        rvalid_o;
    logic        rready_i = 1'b0;
    logic [31:0] awaddr_i = '0;
    logic        awvalid_i = 1'b0;
    logic        awready_o;
    logic [31:0] wdata_i = '0;
    logic [3:0]  wstrb_i = '0;
    logic        wvalid_i = 1'b0;
    logic        wready_o;
    logic [1:0]  bresp_o;
    logic        bvalid_o;
    logic        bready_i = 1'b0;

    axi_lite_sram dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .araddr_i(araddr_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
        .rdata_o(rdata_o), .rresp_o(rresp_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
        .awaddr_i(awaddr_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
        .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
        .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        bit aw_hs, w_hs;
        int n;
        awaddr_i = addr; wdata_i = data; wstrb_i = strb;
        awvalid_i = 1'b1; wvalid_i = 1'b1;
        n = 0;
        while ((awvalid_i || wvalid_i) && n < 50) begin
            @(negedge clk_i);
            aw_hs = awvalid_i && awready_o;
            w_hs  = wvalid_i && wready_o;
            @(posedge clk_i); #1;
            if (aw_hs) awvalid_i = 1'b0;
            if (w_hs)  wvalid_i = 1'b0;
            n++;
        end
        if (awvalid_i || wvalid_i) timeout("write_addr_data_handshake");
        awvalid_i = 1'b0; wvalid_i = 1'b0;
        n = 0;
        while (!bvalid_o && n < 50) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (!bvalid_o) timeout("write_bvalid");
        resp = bresp_o;
        bready_i = 1'b1;
        @(posedge clk_i); #1;
        bready_i = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output int lat);
        bit hs;
        int n;
        araddr_i = addr; arvalid_i = 1'b1;
        hs = 0; n = 0;
        while (!hs && n < 50) begin
            @(negedge clk_i);
            hs = arready_o;
            @(posedge clk_i); #1;
            n++;
        end
        if (!hs) timeout("read_ar_handshake");
        arvalid_i = 1'b0;
        lat = 0;
        while (!rvalid_o && lat < 50) begin
            @(posedge clk_i); #1;
            lat++;
        end
        if (!rvalid_o) timeout("read_rvalid");
        data = rdata_o;
        resp = rresp_o;
        rready_i = 1'b1;
        @(posedge clk_i); #1;
        rready_i = 1'b0;
    endtask

    typedef struct {
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] raddr;
        logic [31:0] rexp;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [1:0]  br, rr;
        logic [31:0] rd;
        int          lat;

        vecs[0] = '{32'h0000_0100, 32'hDEAD_BEEF, 4'hF,    32'h0000_0100, 32'hDEAD_BEEF};
        vecs[1] = '{32'h0000_0204, 32'h1122_3344, 4'hF,    32'h0000_0204, 32'h1122_3344};
        vecs[2] = '{32'h0000_0204, 32'hAABB_CCDD, 4'b0011, 32'h0000_0204, 32'h1122_CCDD};
        vecs[3] = '{32'h0000_0206, 32'h5566_7788, 4'b1000, 32'h0000_0204, 32'h5522_CCDD};
        vecs[4] = '{32'h0000_0100, 32'hFFFF_FFFF, 4'h0,    32'h0000_0100, 32'hDEAD_BEEF};
        vecs[5] = '{32'h0000_0FFC, 32'hCAFE_F00D, 4'hF,    32'h0000_0FFD, 32'hCAFE_F00D};

        // reset behaviour
        #3 rst_ni = 1'b0;
        #1;
        check("reset_rvalid", {31'b0, rvalid_o}, 32'd0);
        check("reset_bvalid", {31'b0, bvalid_o}, 32'd0);
        check("reset_rdata", rdata_o, 32'd0);
        check("reset_rresp", {30'b0, rresp_o}, 32'd0);
        check("reset_bresp", {30'b0, bresp_o}, 32'd0);
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        #1;
        check("release_arready", {31'b0, arready_o}, 32'd1);
        check("release_awready", {31'b0, awready_o}, 32'd1);
        check("release_wready", {31'b0, wready_o}, 32'd1);

        // table-driven write/read pairs
        for (int i = 0; i < 6; i++) begin
            axi_write(vecs[i].waddr, vecs[i].wdata, vecs[i].wstrb, br);
            check($sformatf("vec%0d_bresp", i), {30'b0, br}, 32'd0);
            axi_read(vecs[i].raddr, rd, rr, lat);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].rexp);
            check($sformatf("vec%0d_rresp", i), {30'b0, rr}, 32'd0);
            check($sformatf("vec%0d_rd_latency", i), lat, RD_LAT);
        end

        // W leads AW by three cycles, partial strobe over all-ones
        axi_write(32'h300, 32'hFFFF_FFFF, 4'hF, br);
        wdata_i = 32'h0; wstrb_i = 4'b0101; wvalid_i = 1'b1;
        @(posedge clk_i); #1;
        wvalid_i = 1'b0;
        check("wfirst_wready_low", {31'b0, wready_o}, 32'd0);
        check("wfirst_awready_high", {31'b0, awready_o}, 32'd1);
        repeat (2) @(posedge clk_i);
        #1;
        check("wfirst_no_bvalid", {31'b0, bvalid_o}, 32'd0);
        awaddr_i = 32'h300; awvalid_i = 1'b1;
        @(posedge clk_i); #1;
        awvalid_i = 1'b0;
        @(posedge clk_i); #1;
        check("wfirst_bvalid", {31'b0, bvalid_o}, 32'd1);
        check("wfirst_bresp", {30'b0, bresp_o}, 32'd0);
        bready_i = 1'b1;
        @(posedge clk_i); #1;
        bready_i = 1'b0;
        axi_read(32'h300, rd, rr, lat);
        check("wfirst_rdata", rd, 32'hFF00_FF00);

        // read response held under rready backpressure
        araddr_i = 32'h100; arvalid_i = 1'b1;
        @(posedge clk_i); #1;
        arvalid_i = 1'b0;
        @(posedge clk_i); #1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall%0d_rvalid", i), {31'b0, rvalid_o}, 32'd1);
            check($sformatf("stall%0d_rdata", i), rdata_o, 32'hDEAD_BEEF);
            check($sformatf("stall%0d_arready", i), {31'b0, arready_o}, 32'd0);
            @(posedge clk_i); #1;
        end
        rready_i = 1'b1;
        @(posedge clk_i); #1;
        rready_i = 1'b0;
        check("stall_release_rvalid", {31'b0, rvalid_o}, 32'd0);
        check("stall_release_arready", {31'b0, arready_o}, 32'd1);

        // write commit and read sample on the same edge
        axi_write(32'h10, 32'h0, 4'hF, br);
        awaddr_i = 32'h10; wdata_i = 32'h1234_5678; wstrb_i = 4'hF; araddr_i = 32'h10;
        awvalid_i = 1'b1; wvalid_i = 1'b1; arvalid_i = 1'b1;
        @(negedge clk_i);
        check("collide_ready_all", {29'b0, arready_o, awready_o, wready_o}, 32'd7);
        @(posedge clk_i); #1;
        awvalid_i = 1'b0; wvalid_i = 1'b0; arvalid_i = 1'b0;
        @(posedge clk_i); #1;
        check("collide_rvalid", {31'b0, rvalid_o}, 32'd1);
        check("collide_bvalid", {31'b0, bvalid_o}, 32'd1);
        check("collide_old_data", rdata_o, 32'h0);
        rready_i = 1'b1; bready_i = 1'b1;
        @(posedge clk_i); #1;
        rready_i = 1'b0; bready_i = 1'b0;
        axi_read(32'h10, rd, rr, lat);
        check("collide_new_data", rd, 32'h1234_5678);

        // reset pulse while a write waits to commit
        axi_write(32'h20, 32'hA5A5_A5A5, 4'hF, br);
        awaddr_i = 32'h20; wdata_i = 32'h0; wstrb_i = 4'hF;
        awvalid_i = 1'b1; wvalid_i = 1'b1;
        @(posedge clk_i); #1;
        awvalid_i = 1'b0; wvalid_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        check("midrst_bvalid_now", {31'b0, bvalid_o}, 32'd0);
        #2 rst_ni = 1'b1;
        @(posedge clk_i); #1;
        check("midrst_bvalid_after", {31'b0, bvalid_o}, 32'd0);
        check("midrst_ready", {30'b0, awready_o, wready_o}, 32'd3);
        axi_read(32'h20, rd, rr, lat);
        check("midrst_word_kept", rd, 32'hA5A5_A5A5);

        // out-of-range address
        axi_write(32'h0, 32'h0BAD_F00D, 4'hF, br);
        axi_write(32'h1000, 32'h7777_7777, 4'hF, br);
`ifdef AXI_LITE_SRAM_DECERR_EN
        check("oor_bresp", {30'b0, br}, 32'd3);
`else
        check("oor_bresp", {30'b0, br}, 32'd0);
`endif
        axi_read(32'h1000, rd, rr, lat);
        check("oor_rd_latency", lat, RD_LAT);
`ifdef AXI_LITE_SRAM_DECERR_EN
        check("oor_rresp", {30'b0, rr}, 32'd3);
        check("oor_rdata", rd, 32'h0);
        axi_read(32'h0, rd, rr, lat);
        check("oor_word0_untouched", rd, 32'h0BAD_F00D);
`else
        check("oor_rresp", {30'b0, rr}, 32'd0);
        check("oor_rdata", rd, 32'h7777_7777);
        axi_read(32'h0, rd, rr, lat);
        check("oor_word0_wrapped", rd, 32'h7777_7777);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
